// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, instruction
// size and the default reset address.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INST_BYTES       = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Word-align a fetch address; the low two bits carry no meaning.
  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // Sequential successor; wraps naturally at 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO holding {pc, instruction} pairs. Pointers and count
// are reset; storage is not. Push while full is accepted only with a same-cycle pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef logic [PW-1:0]  ptr_t;
  typedef logic [PW:0]    cnt_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  logic             push_s;
  logic             pop_s;

  assign full_o  = (count_q == cnt_t'(DEPTH));
  assign empty_o = (count_q == cnt_t'(0));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_s  = pop_i && !empty_o;
  assign push_s = push_i && (!full_o || pop_s) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = ptr_t'(0);
      rd_ptr_d = ptr_t'(0);
      count_d  = cnt_t'(0);
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= ptr_t'(0);
      rd_ptr_q <= ptr_t'(0);
      count_q  <= cnt_t'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // At full with a pop, the write lands in the slot being vacated this cycle.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetcher: walks fetch_pc through an asynchronous-read
// memory, buffering words in a prefetch queue, with redirect and halt control.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [31:0]                  imem_addr,
  input  logic [31:0]                  imem_dout,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  input  logic                         halt_req,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [31:0]                  inst,
  output logic [31:0]                  inst_pc,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count,
  output logic                         halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         flush_s;
  logic         push_s;
  logic         pop_s;
  logic         full_s;
  logic         empty_s;
  logic [63:0]  head_s;

  assign imem_addr  = fetch_pc_q;
  assign inst_valid = !empty_s;
  assign inst_pc    = head_s[63:32];
  assign inst       = head_s[31:0];
  assign halted     = (state_q == ST_HALTED);

  // A redirect is only honoured once the memory has settled.
  assign flush_s = redirect_valid && (state_q != ST_WAIT);
  assign pop_s   = inst_valid && inst_ready;
  assign push_s  = (state_q == ST_RUN) && !redirect_valid && !halt_req
                   && (!full_s || pop_s);

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (64)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i ({fetch_pc_q, imem_dout}),
    .rdata_o (head_s),
    .count_o (queue_count),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_WAIT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req && !redirect_valid) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (!halt_req) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
    if (flush_s) begin
      fetch_pc_d = pc_align(redirect_pc);
    end else if (push_s) begin
      fetch_pc_d = pc_next(fetch_pc_q);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_WAIT;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scenario bench for instruction_fetch_unit: per-feature tasks plus a
// scoreboard of expected {pc, inst} pairs consumed at the output handshake.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  queue_count;
  logic        halted;

  int checks;
  int errors;
  int consumed;
  logic [63:0] exp_q[$];

  instruction_fetch_unit #(
    .QUEUE_DEPTH (4),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .queue_count    (queue_count),
    .halted         (halted)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    return a ^ 32'h5A5A_0013;
  endfunction

  assign imem_dout = imem_word(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, imem_word(pc)});
  endtask

  // Output monitor: a handshake seen at the falling edge completes on the next rise.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset && inst_valid && inst_ready) begin
        consumed = consumed + 1;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL scoreboard_unexpected got pc=%h inst=%h required nothing", inst_pc, inst);
        end else begin
          e = exp_q.pop_front();
          if ({inst_pc, inst} !== e) begin
            errors = errors + 1;
            $display("FAIL scoreboard got pc=%h inst=%h required pc=%h inst=%h",
                     inst_pc, inst, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] req);
    checks = checks + 1;
    if (got !== req) begin
      errors = errors + 1;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic do_reset(input logic ready_at_release);
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0; inst_ready = 1'b0;
    tick(); tick();
    exp_q.delete();
    inst_ready = ready_at_release;
    reset = 1'b0;
  endtask

  task automatic consume(input int n);
    int target;
    bit done;
    target = consumed + n;
    done = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      if (consumed >= target) done = 1'b1;
    end
    inst_ready = 1'b0;
    checks = checks + 1;
    if (!done || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL consume got %0d handshakes left %0d required %0d left 0",
               consumed - (target - n), exp_q.size(), n);
    end
  endtask

  task automatic wait_count(input logic [2:0] target);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (queue_count == target) done = 1'b1;
      else tick();
    end
    checks = checks + 1;
    if (!done) begin
      errors = errors + 1;
      $display("FAIL wait_count got %0d required %0d", queue_count, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080; halt_req = 1'b0; inst_ready = 1'b1;
    tick(); tick();
    chk32("reset_count", {29'd0, queue_count}, 32'd0);
    chk32("reset_valid", {31'd0, inst_valid}, 32'd0);
    chk32("reset_halted", {31'd0, halted}, 32'd0);
    chk32("reset_addr", imem_addr, 32'h0000_0000);
  endtask

  task automatic test_first_fetch();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
    tick();
    chk32("wait_no_valid", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk32("b2b_valid", {31'd0, inst_valid}, 32'd1);
      chk32("b2b_pc", inst_pc, 32'(i * 4));
    end
    chk32("first_inst_word", imem_word(32'h0), 32'h0050_0093);
    tick();
    inst_ready = 1'b0;
    chk32("b2b_drained", exp_q.size(), 32'd0);
  endtask

  task automatic test_saturate_and_pushpop();
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk32("sat_count", {29'd0, queue_count}, 32'd4);
    chk32("sat_addr", imem_addr, 32'h0000_0010);
    chk32("sat_head_pc", inst_pc, 32'h0000_0000);
    chk32("sat_head_inst", inst, 32'h0050_0093);
    for (int i = 0; i < 5; i++) expect_pc(32'(i * 4));
    inst_ready = 1'b1;
    tick();
    chk32("pushpop_count", {29'd0, queue_count}, 32'd4);
    chk32("pushpop_addr", imem_addr, 32'h0000_0014);
    chk32("pushpop_head", inst_pc, 32'h0000_0004);
    consume(4);
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    wait_count(3'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk32("redir_count", {29'd0, queue_count}, 32'd0);
    chk32("redir_addr", imem_addr, 32'h0000_0100);
    chk32("redir_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk32("redir_first_pc", inst_pc, 32'h0000_0100);
    expect_pc(32'h0000_0100);
    expect_pc(32'h0000_0104);
    consume(2);
  endtask

  task automatic test_halt();
    do_reset(1'b0);
    wait_count(3'd2);
    halt_req = 1'b1;
    tick();
    chk32("halt_flag", {31'd0, halted}, 32'd1);
    tick();
    chk32("halt_count", {29'd0, queue_count}, 32'd2);
    chk32("halt_addr", imem_addr, 32'h0000_0008);
    expect_pc(32'h0000_0000);
    expect_pc(32'h0000_0004);
    consume(2);
    chk32("halt_drained", {29'd0, queue_count}, 32'd0);
    chk32("halt_addr_held", imem_addr, 32'h0000_0008);
    halt_req = 1'b0;
    tick();
    chk32("resume_flag", {31'd0, halted}, 32'd0);
    tick();
    chk32("resume_pc", inst_pc, 32'h0000_0008);
    expect_pc(32'h0000_0008);
    consume(1);
    halt_req = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0041;
    tick();
    redirect_valid = 1'b0;
    chk32("hredir_halted", {31'd0, halted}, 32'd1);
    chk32("hredir_count", {29'd0, queue_count}, 32'd0);
    chk32("hredir_addr", imem_addr, 32'h0000_0040);
    halt_req = 1'b0;
    expect_pc(32'h0000_0040);
    consume(1);
  endtask

  task automatic test_wrap_and_wait_redirect();
    do_reset(1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk32("wait_redir_ignored", inst_pc, 32'h0000_0000);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chk32("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk32("wrap_next_addr", imem_addr, 32'h0000_0000);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0000_0000);
    expect_pc(32'h0000_0004);
    consume(3);
  endtask

  task automatic test_reset_midstream();
    do_reset(1'b0);
    wait_count(3'd4);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; inst_ready = 1'b1;
    exp_q.delete();
    tick();
    chk32("mid_count", {29'd0, queue_count}, 32'd0);
    chk32("mid_addr", imem_addr, 32'h0000_0000);
    chk32("mid_valid", {31'd0, inst_valid}, 32'd0);
    chk32("mid_halted", {31'd0, halted}, 32'd0);
    reset = 1'b0; redirect_valid = 1'b0;
    expect_pc(32'h0000_0000);
    consume(1);
  endtask

  initial begin
    checks = 0; errors = 0; consumed = 0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0; inst_ready = 1'b0;
    test_reset();
    test_first_fetch();
    test_saturate_and_pushpop();
    test_redirect();
    test_halt();
    test_wrap_and_wait_redirect();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, giving prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port imem_addr, output, 32, byte address presented to the asynchronous-read instruction memory.
REQ-006 SHALL have port imem_dout, input, 32, instruction word returned combinationally for imem_addr.
REQ-007 SHALL have port redirect_valid, input, 1, request to restart fetching at redirect_pc.
REQ-008 SHALL have port redirect_pc, input, 32, new fetch address; bits [1:0] are ignored and treated as 0.
REQ-009 SHALL have port halt_req, input, 1, level request to stop issuing new fetches.
REQ-010 SHALL have port inst_valid, output, 1, queue head holds a valid instruction.
REQ-011 SHALL have port inst_ready, input, 1, consumer accepts the head this cycle.
REQ-012 SHALL have port inst, output, 32, instruction word at queue head.
REQ-013 SHALL have port inst_pc, output, 32, byte address of the head instruction.
REQ-014 SHALL have port queue_count, output, $clog2(QUEUE_DEPTH)+1, current queue occupancy.
REQ-015 SHALL have port halted, output, 1, high while in state HALTED.

Function
REQ-016 SHALL implement states WAIT (memory settling), RUN, HALTED.
REQ-017 SHALL go WAIT -> RUN unconditionally one cycle after reset deasserts; no fetch is issued in WAIT.
REQ-018 SHALL go RUN -> HALTED when halt_req=1 and redirect_valid=0; HALTED -> RUN when halt_req=0.
REQ-019 SHALL drive imem_addr = fetch_pc continuously in every state.
REQ-020 SHALL push {fetch_pc, imem_dout} into the queue on a cycle where state=RUN, redirect_valid=0, halt_req=0, and (queue not full or a pop occurs that cycle); fetch_pc then advances by 4.
REQ-021 SHALL pop the head when inst_valid=1 and inst_ready=1; inst_valid = (queue_count != 0).
REQ-022 SHALL allow push and pop in the same cycle, including at full, leaving queue_count unchanged.
REQ-023 SHALL, on redirect_valid=1 in RUN or HALTED, flush all entries (queue_count=0 next cycle), set fetch_pc to {redirect_pc[31:2],2'b00}, and push nothing that cycle; a simultaneous pop is treated as accepted.
REQ-024 SHALL, on redirect in HALTED with halt_req still 1, update fetch_pc and flush but remain HALTED.
REQ-025 SHALL ignore redirect_valid in WAIT.
REQ-026 SHALL wrap fetch_pc modulo 2^32 (32'hFFFF_FFFC + 4 = 0) without any bounds check.
REQ-027 SHALL preserve queue contents and order in HALTED; the consumer may keep draining.
REQ-028 SHALL present inst and inst_pc from registered queue storage, so the queue head is stable while inst_valid=1 and inst_ready=0.

Reset
REQ-029 SHALL, while reset=1, set state=WAIT, fetch_pc=RESET_PC, queue_count=0, inst_valid=0, halted=0.
REQ-030 SHALL let reset override redirect, halt, push and pop in the same cycle, discarding all queued entries.
REQ-031 SHALL leave queue data storage uninitialised; only pointers and count are reset.

Structure
REQ-032 SHALL place state encoding (WAIT/RUN/HALTED), INST_BYTES=4 and default RESET_PC in shared package fetch_pkg.
REQ-033 SHALL implement the queue as one sub-module fetch_queue (synchronous FIFO with push, pop, flush, count, full, empty).
REQ-034 SHALL keep the FSM and fetch_pc in instruction_fetch_unit itself.

Verification
REQ-035 SHALL cover reset release, memory word0=32'h00500093, inst_ready=1 -> first inst_valid two cycles after reset falls, inst=32'h00500093, inst_pc=0, then pcs 4, 8, 12 back-to-back.
REQ-036 SHALL cover inst_ready=0 for 10 cycles, QUEUE_DEPTH=4 -> queue_count saturates at 4, imem_addr holds 32'h10, head stays pc 0.
REQ-037 SHALL cover queue full plus inst_ready=1 -> push and pop same cycle, queue_count stays 4, next pushed pc 32'h10.
REQ-038 SHALL cover redirect_valid=1, redirect_pc=32'h0000_0103 with 3 entries queued -> next cycle queue_count=0, imem_addr=32'h100, first new inst_pc=32'h100.
REQ-039 SHALL cover halt_req=1 with 2 entries queued -> halted=1, no further pushes, both entries drain in order, fetch_pc unchanged; halt_req=0 -> fetch resumes at held pc.
REQ-040 SHALL cover reset asserted mid-stream with queue full and redirect_valid=1 -> queue_count=0, imem_addr=RESET_PC, redirect ignored.
